// File: rtl/fp_add_arbiter.sv
// Round-robin front end sharing one pipelined fp_add between NUM_REQ requesters.
// A tag shift register matched to the adder latency routes each result home.
module fp_add_arbiter #(
    parameter int DATAWIDTH   = 32,
    parameter int NUM_REQ     = 4,
    parameter int ADD_LATENCY = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ*DATAWIDTH-1:0]   req_a,
    input  logic [NUM_REQ*DATAWIDTH-1:0]   req_b,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic                           hold,
    output logic [DATAWIDTH-1:0]           add_a,
    output logic [DATAWIDTH-1:0]           add_b,
    output logic                           add_ena,
    input  logic [DATAWIDTH-1:0]           add_s,
    input  logic                           add_s_ena,
    input  logic                           add_nan,
    input  logic                           add_over,
    output logic [NUM_REQ-1:0]             rsp_valid,
    output logic [DATAWIDTH-1:0]           rsp_s,
    output logic                           rsp_nan,
    output logic                           rsp_over,
    output logic                           idle,
    output logic                           err
);

    localparam int IDW = $clog2(NUM_REQ);
    localparam int L   = ADD_LATENCY;

    logic [IDW-1:0]       ptr_q, ptr_d;
    logic [DATAWIDTH-1:0] add_a_q, add_a_d;
    logic [DATAWIDTH-1:0] add_b_q, add_b_d;
    logic                 add_ena_q, add_ena_d;
    logic [IDW-1:0]       iss_id_q, iss_id_d;
    logic [L-1:0]         tag_v_q, tag_v_d;
    logic [IDW-1:0]       tag_id_q [L];
    logic [IDW-1:0]       tag_id_d [L];
    logic [NUM_REQ-1:0]   rsp_valid_q, rsp_valid_d;
    logic [DATAWIDTH-1:0] rsp_s_q, rsp_s_d;
    logic                 rsp_nan_q, rsp_nan_d;
    logic                 rsp_over_q, rsp_over_d;
    logic                 err_q, err_d;

    logic           gnt_found;
    logic [IDW-1:0] gnt_id;
    logic [IDW-1:0] cand;
    logic           xfer;
    logic           last_v;
    int             s;

    // Rotating search starting at the priority pointer
    always_comb begin
        gnt_found = 1'b0;
        gnt_id    = '0;
        cand      = '0;
        s         = 0;
        req_ready = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            s = int'(ptr_q) + k;
            if (s >= NUM_REQ) s = s - NUM_REQ;
            cand = IDW'(s);
            if (!gnt_found && req_valid[cand]) begin
                gnt_found = 1'b1;
                gnt_id    = cand;
            end
        end
        if (gnt_found && !hold && !rst) req_ready[gnt_id] = 1'b1;
    end

    assign xfer   = |(req_valid & req_ready);
    assign last_v = tag_v_q[L-1];

    always_comb begin
        ptr_d       = ptr_q;
        add_a_d     = add_a_q;
        add_b_d     = add_b_q;
        add_ena_d   = xfer;
        iss_id_d    = iss_id_q;
        rsp_valid_d = '0;
        rsp_s_d     = rsp_s_q;
        rsp_nan_d   = rsp_nan_q;
        rsp_over_d  = rsp_over_q;
        err_d       = err_q | (add_s_ena != last_v);
        tag_v_d     = tag_v_q;
        tag_id_d    = tag_id_q;
        if (xfer) begin
            if (gnt_id == IDW'(NUM_REQ - 1)) ptr_d = '0;
            else ptr_d = gnt_id + 1'b1;
            add_a_d  = req_a[gnt_id*DATAWIDTH +: DATAWIDTH];
            add_b_d  = req_b[gnt_id*DATAWIDTH +: DATAWIDTH];
            iss_id_d = gnt_id;
        end
        tag_v_d[0]  = add_ena_q;
        tag_id_d[0] = iss_id_q;
        for (int j = 1; j < L; j++) begin
            tag_v_d[j]  = tag_v_q[j-1];
            tag_id_d[j] = tag_id_q[j-1];
        end
        // Unmatched results are dropped; only tagged ones respond
        if (add_s_ena && last_v) begin
            rsp_valid_d[tag_id_q[L-1]] = 1'b1;
            rsp_s_d    = add_s;
            rsp_nan_d  = add_nan;
            rsp_over_d = add_over;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q       <= '0;
            add_a_q     <= '0;
            add_b_q     <= '0;
            add_ena_q   <= 1'b0;
            iss_id_q    <= '0;
            tag_v_q     <= '0;
            for (int j = 0; j < L; j++) tag_id_q[j] <= '0;
            rsp_valid_q <= '0;
            rsp_s_q     <= '0;
            rsp_nan_q   <= 1'b0;
            rsp_over_q  <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            ptr_q       <= ptr_d;
            add_a_q     <= add_a_d;
            add_b_q     <= add_b_d;
            add_ena_q   <= add_ena_d;
            iss_id_q    <= iss_id_d;
            tag_v_q     <= tag_v_d;
            tag_id_q    <= tag_id_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_s_q     <= rsp_s_d;
            rsp_nan_q   <= rsp_nan_d;
            rsp_over_q  <= rsp_over_d;
            err_q       <= err_d;
        end
    end

    assign add_a     = add_a_q;
    assign add_b     = add_b_q;
    assign add_ena   = add_ena_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_s     = rsp_s_q;
    assign rsp_nan   = rsp_nan_q;
    assign rsp_over  = rsp_over_q;
    assign err       = err_q;
    assign idle      = !(|tag_v_q) && !add_ena_q;

endmodule
